// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// =============================================================================
// bus_arbiter_rr : round-robin bus arbiter that shifts in a serial device
//                  address from the granted master, then routes it to a slave.
// Revision: 1.0
// =============================================================================
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int DEV_ADDR_W  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_breq,
  output logic [NUM_MASTERS-1:0] m_bgrant,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_SLAVES-1:0]  s_mode,
  output logic [NUM_SLAVES-1:0]  s_wr_bus,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  input  logic [NUM_SLAVES-1:0]  s_rd_bus,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid,
  output logic                   timeout_err
);

  localparam int c_G_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int c_SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int c_BIT_W = $clog2(DEV_ADDR_W + 1);
  localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [c_G_W-1:0]      c_LAST_M   = c_G_W'(NUM_MASTERS - 1);
  localparam logic [c_BIT_W-1:0]    c_BIT_LAST = c_BIT_W'(DEV_ADDR_W - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [DEV_ADDR_W:0]   c_NSLV     = (DEV_ADDR_W + 1)'(NUM_SLAVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ACK   = 3'd2,
    S_ROUTE = 3'd3,
    S_CLEAN = 3'd4
  } state_t;

  state_t                  r_state;
  logic [c_G_W-1:0]        r_g;
  logic [c_G_W-1:0]        r_last;
  logic [DEV_ADDR_W-1:0]   r_addr;
  logic [c_BIT_W-1:0]      r_bitcnt;
  logic [c_CNT_W-1:0]      r_idle_cnt;
  logic [c_SEL_W-1:0]      r_sel;
  logic                    r_ack;
  logic                    r_timeout;

  logic [c_G_W-1:0]        w_rr_g;
  logic                    w_rr_found;
  logic [DEV_ADDR_W-1:0]   w_addr_next;
  logic                    w_ack_next;
  logic                    w_g_breq;
  logic                    w_g_valid;
  logic                    w_g_ready;
  logic                    w_s_valid;

  // First requester found scanning upward from the master after the last grant
  always_comb begin
    w_rr_g     = '0;
    w_rr_found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!w_rr_found && m_breq[(int'(r_last) + i) % NUM_MASTERS]) begin
        w_rr_found = 1'b1;
        w_rr_g     = c_G_W'((int'(r_last) + i) % NUM_MASTERS);
      end
    end
  end

  assign w_g_breq    = m_breq[r_g];
  assign w_g_valid   = m_master_valid[r_g];
  assign w_g_ready   = m_master_ready[r_g];
  assign w_s_valid   = s_slave_valid[r_sel];
  assign w_addr_next = (r_addr << 1) | DEV_ADDR_W'(m_wr_bus[r_g]);
  assign w_ack_next  = ({1'b0, w_addr_next} < c_NSLV);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_g        <= '0;
      r_last     <= c_LAST_M;
      r_addr     <= '0;
      r_bitcnt   <= '0;
      r_idle_cnt <= '0;
      r_sel      <= '0;
      r_ack      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rr_found) begin
            r_g     <= w_rr_g;
            r_last  <= w_rr_g;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!w_g_breq) begin
            r_state <= S_CLEAN;
          end else if (w_g_valid) begin
            r_addr   <= w_addr_next;
            r_bitcnt <= r_bitcnt + c_BIT_W'(1);
            if (r_bitcnt == c_BIT_LAST) begin
              r_sel   <= w_ack_next ? c_SEL_W'(w_addr_next) : '0;
              r_ack   <= w_ack_next;
              r_state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (!w_g_breq) begin
            r_state <= S_CLEAN;
          end else if (w_g_ready) begin
            r_state <= r_ack ? S_ROUTE : S_CLEAN;
          end
        end
        S_ROUTE: begin
          if (!w_g_breq) begin
            r_state <= S_CLEAN;
          end else if (w_g_valid || w_s_valid) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == c_CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_CLEAN;
          end else begin
            r_idle_cnt <= r_idle_cnt + c_CNT_W'(1);
          end
        end
        S_CLEAN: begin
          r_addr     <= '0;
          r_bitcnt   <= '0;
          r_idle_cnt <= '0;
          r_sel      <= '0;
          r_ack      <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; ROUTE is a zero-latency crossbar
  always_comb begin
    m_bgrant       = '0;
    m_rd_bus       = '0;
    m_slave_ready  = '0;
    m_slave_valid  = '0;
    m_ack          = '0;
    s_mode         = '0;
    s_wr_bus       = '0;
    s_master_valid = '0;
    s_master_ready = '0;
    case (r_state)
      S_ADDR: begin
        m_bgrant[r_g]      = 1'b1;
        m_slave_ready[r_g] = 1'b1;
      end
      S_ACK: begin
        m_bgrant[r_g]      = 1'b1;
        m_slave_valid[r_g] = 1'b1;
        m_ack[r_g]         = r_ack;
      end
      S_ROUTE: begin
        m_bgrant[r_g]         = 1'b1;
        s_mode[r_sel]         = m_mode[r_g];
        s_wr_bus[r_sel]       = m_wr_bus[r_g];
        s_master_valid[r_sel] = m_master_valid[r_g];
        s_master_ready[r_sel] = m_master_ready[r_g];
        m_rd_bus[r_g]         = s_rd_bus[r_sel];
        m_slave_ready[r_g]    = s_slave_ready[r_sel];
        m_slave_valid[r_g]    = s_slave_valid[r_sel];
      end
      default: ;
    endcase
  end

  assign timeout_err = r_timeout;

endmodule
`default_nettype wire
